div_issue_ctrl: RTL and testbench

Sequences the shared 32-bit divider IP pair (signed and unsigned, AXI-stream dividend/divisor/dout channels) on behalf of the EXE stage. It replaces ad-hoc per-instruction handshake logic with a single FSM. The FSM accepts one div/mod request, drives each IP input channel independently until accepted, and captures the one-cycle dout pulse. It holds the selected quotient/remainder until EXE consumes it, and drains in-flight results on pipeline cancel.

---
 rtl/div_issue_ctrl_pkg.sv | 31 +++
 rtl/div_issue_ctrl_if.sv | 44 ++++
 rtl/div_chan_hs.sv | 33 +++
 rtl/div_issue_ctrl.sv | 162 ++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg: shared types and constants for the divider issue controller.
//   div_state_e    : controller FSM encoding (IDLE..DRAIN)
//   DIV_SIGNED/UNS : index of each divider IP in the 2-bit tvalid/tready/dout_tvalid buses
//   CH_*           : index of each AXI-stream input channel inside the controller
//   DOUT_Q/R_LSB   : slice positions of quotient / remainder in the 64-bit dout word
package div_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } div_state_e;

    localparam int XLEN         = 32;
    localparam int DIV_SIGNED   = 1;
    localparam int DIV_UNSIGNED = 0;
    localparam int NUM_IP       = 2;
    localparam int NUM_CH       = 2;
    localparam int CH_DIVIDEND  = 0;
    localparam int CH_DIVISOR   = 1;
    localparam int DOUT_Q_LSB   = 32;
    localparam int DOUT_R_LSB   = 0;

    // Pick quotient or remainder out of a packed {quotient, remainder} dout word.
    function automatic logic [XLEN-1:0] dout_half(input logic [2*XLEN-1:0] dout, input logic is_mod);
        return is_mod ? dout[DOUT_R_LSB +: XLEN] : dout[DOUT_Q_LSB +: XLEN];
    endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: bundles the EXE request/response handshake and the divider
// IP AXI-stream channels.
//   master : the controller's view (drives req_ready, resp_*, err_timeout,
//            tdata and tvalid; receives requests, tready and dout)
//   slave  : the environment's view (EXE stage plus the two divider IPs)
// Two-bit buses are indexed [1]=signed IP, [0]=unsigned IP.
interface div_issue_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_signed;
    logic        req_mod;
    logic [31:0] req_dividend;
    logic [31:0] req_divisor;
    logic        cancel;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        err_timeout;
    logic [31:0] div_dividend_tdata;
    logic [31:0] div_divisor_tdata;
    logic [1:0]  dividend_tvalid;
    logic [1:0]  divisor_tvalid;
    logic [1:0]  dividend_tready;
    logic [1:0]  divisor_tready;
    logic [1:0]  dout_tvalid;
    logic [63:0] dout_sdata;
    logic [63:0] dout_udata;

    modport master (
        input  req_valid, req_signed, req_mod, req_dividend, req_divisor, cancel,
               resp_ready, dividend_tready, divisor_tready, dout_tvalid, dout_sdata, dout_udata,
        output req_ready, resp_valid, resp_result, err_timeout,
               div_dividend_tdata, div_divisor_tdata, dividend_tvalid, divisor_tvalid
    );

    modport slave (
        output req_valid, req_signed, req_mod, req_dividend, req_divisor, cancel,
               resp_ready, dividend_tready, divisor_tready, dout_tvalid, dout_sdata, dout_udata,
        input  req_ready, resp_valid, resp_result, err_timeout,
               div_dividend_tdata, div_divisor_tdata, dividend_tvalid, divisor_tvalid
    );

endinterface

// File: rtl/div_chan_hs.sv
// div_chan_hs: one AXI-stream source channel.
//   start    : raise tvalid for a new beat, clear accepted
//   clear    : abandon the beat (tvalid and accepted drop)
//   tready   : sink ready for the IP currently selected
//   tvalid   : held high until tvalid&tready, then dropped on the next edge
//   accepted : set once the beat has been taken, held until start/clear
module div_chan_hs (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic clear,
    input  logic tready,
    output logic tvalid,
    output logic accepted
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tvalid   <= 1'b0;
            accepted <= 1'b0;
        end else if (clear) begin
            tvalid   <= 1'b0;
            accepted <= 1'b0;
        end else if (start) begin
            tvalid   <= 1'b1;
            accepted <= 1'b0;
        end else if (tvalid && tready) begin
            tvalid   <= 1'b0;
            accepted <= 1'b1;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequences the shared signed/unsigned 32-bit divider IPs for EXE.
// Accepts one div/mod request, issues dividend and divisor to the selected IP
// (each channel handshakes independently), captures the single-cycle dout pulse,
// and holds the chosen quotient/remainder until EXE takes it. A cancel after
// any channel has been accepted drains the IP's result so the next op starts clean.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : request/response and IP channels (see div_issue_ctrl_if)
//   TIMEOUT     : WAIT cycles before the sticky err_timeout is raised
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             resetn,
    div_issue_ctrl_if.master bus
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    div_state_e state, state_nxt;

    logic                           sel_q;
    logic                           mod_q;
    logic [XLEN-1:0]                dvd_q;
    logic [XLEN-1:0]                dvs_q;
    logic [XLEN-1:0]                res_q;
    logic [CW-1:0]                  cnt;
    logic                           err_q;
    logic                           req_ready;
    logic                           ch_start;
    logic                           ch_clear;
    logic                           capture;
    logic                           cnt_clr;
    logic                           dout_hit;
    logic [2*XLEN-1:0]              dout_word;
    logic [NUM_CH-1:0]              ch_tvalid;
    logic [NUM_CH-1:0]              ch_tready;
    logic [NUM_CH-1:0]              ch_acc;
    logic [NUM_CH-1:0]              ch_done;
    logic [NUM_CH-1:0][NUM_IP-1:0]  ip_tready;

    assign ip_tready[CH_DIVIDEND] = bus.dividend_tready;
    assign ip_tready[CH_DIVISOR]  = bus.divisor_tready;

    // One handshake source per input channel; the IP select steers tready in
    // and tvalid out, so the non-selected IP never sees a valid.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_tready[g] = ip_tready[g][sel_q];
        div_chan_hs u_chan (
            .clk      (clk),
            .resetn   (resetn),
            .start    (ch_start),
            .clear    (ch_clear),
            .tready   (ch_tready[g]),
            .tvalid   (ch_tvalid[g]),
            .accepted (ch_acc[g])
        );
    end

    // A channel counts as accepted in the cycle its handshake completes.
    assign ch_done   = ch_acc | (ch_tvalid & ch_tready);
    assign dout_hit  = bus.dout_tvalid[sel_q];
    assign dout_word = (sel_q == 1'(DIV_SIGNED)) ? bus.dout_sdata : bus.dout_udata;
    assign req_ready = (state == ST_IDLE) && !bus.cancel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ch_start  = 1'b0;
        ch_clear  = 1'b0;
        capture   = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid && req_ready) begin
                    ch_start  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.cancel) begin
                    // Nothing reached the IP yet: safe to abandon outright.
                    // Otherwise the pair must be completed and its result drained.
                    if (ch_done == '0) begin
                        ch_clear  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end else if (&ch_done) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A result landing with a cancel is simply dropped; there is
                // nothing left in flight to drain.
                if (dout_hit) begin
                    capture   = !bus.cancel;
                    state_nxt = bus.cancel ? ST_IDLE : ST_DONE;
                end else if (bus.cancel) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (bus.cancel || bus.resp_ready) state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (&ch_acc && dout_hit) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_q <= 1'(DIV_UNSIGNED);
            mod_q <= 1'b0;
            dvd_q <= '0;
            dvs_q <= '0;
            res_q <= '0;
        end else begin
            if (ch_start) begin
                sel_q <= bus.req_signed;
                mod_q <= bus.req_mod;
                dvd_q <= bus.req_dividend;
                dvs_q <= bus.req_divisor;
            end
            if (capture) res_q <= dout_half(dout_word, mod_q);
        end
    end

    // WAIT-cycle counter saturates at TIMEOUT; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (cnt_clr)
                cnt <= '0;
            else if (state == ST_WAIT && cnt != CW'(TIMEOUT))
                cnt <= cnt + CW'(1);
            if (state == ST_WAIT && cnt == CW'(TIMEOUT - 1))
                err_q <= 1'b1;
        end
    end

    assign bus.req_ready          = req_ready;
    assign bus.resp_valid         = (state == ST_DONE) && !bus.cancel;
    assign bus.resp_result        = res_q;
    assign bus.err_timeout        = err_q;
    assign bus.div_dividend_tdata = dvd_q;
    assign bus.div_divisor_tdata  = dvs_q;
    assign bus.dividend_tvalid    = sel_q ? {ch_tvalid[CH_DIVIDEND], 1'b0} : {1'b0, ch_tvalid[CH_DIVIDEND]};
    assign bus.divisor_tvalid     = sel_q ? {ch_tvalid[CH_DIVISOR], 1'b0}  : {1'b0, ch_tvalid[CH_DIVISOR]};

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed bench for div_issue_ctrl (TIMEOUT=8). The bench
// plays both EXE and the divider IPs, driving tready/dout cycle by cycle with
// hand-computed divider results.
module tb_div_issue_ctrl;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_sel     = 1'b0;

    // run_op observations
    logic [1:0]  seen;
    int          dh, vh;
    logic [31:0] dd, vd, res;
    logic        rv;

    div_issue_ctrl_if bus ();

    div_issue_ctrl #(.TIMEOUT(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // IP protocol check: a dout pulse must target only the issued IP, only in
    // WAIT/DRAIN, and never coincide with an input-channel handshake.
    always @(negedge clk) begin
        if (resetn && bus.dout_tvalid != 2'b00) begin
            vectors++;
            if (bus.dout_tvalid !== (exp_sel ? 2'b10 : 2'b01) || bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 ||
                ((bus.dividend_tvalid & bus.dividend_tready) | (bus.divisor_tvalid & bus.divisor_tready)) != 2'b00) begin
                $display("FAIL dout_protocol: dout_tvalid=%b req_ready=%b resp_valid=%b, required lone pulse on IP %0d while busy",
                         bus.dout_tvalid, bus.req_ready, bus.resp_valid, exp_sel);
                miscompares++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid = 1'b0;  bus.req_signed = 1'b0;  bus.req_mod = 1'b0;
        bus.req_dividend = '0; bus.req_divisor = '0;   bus.cancel = 1'b0;
        bus.resp_ready = 1'b0; bus.dividend_tready = '0; bus.divisor_tready = '0;
        bus.dout_tvalid = '0;  bus.dout_sdata = '0;    bus.dout_udata = '0;
    endtask

    // Present one request from IDLE; returns one cycle later with the op in ISSUE.
    task automatic issue(input logic s, input logic m, input logic [31:0] a, input logic [31:0] b);
        exp_sel = s;
        bus.req_valid = 1'b1; bus.req_signed = s; bus.req_mod = m;
        bus.req_dividend = a; bus.req_divisor = b;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Full op: tready per channel dvd_dly/dvs_dly cycles after issue, dout pulse
    // lat cycles into WAIT. The non-selected IP carries ~dout to expose a wrong mux.
    task automatic run_op(input logic s, input logic m, input logic [31:0] a, input logic [31:0] b,
                          input int dvd_dly, input int dvs_dly, input int lat, input logic [63:0] dout);
        logic [1:0] mask;
        int last;
        mask = s ? 2'b10 : 2'b01;
        seen = '0; dh = 0; vh = 0;
        issue(s, m, a, b);
        dd = bus.div_dividend_tdata;
        vd = bus.div_divisor_tdata;
        last = (dvd_dly > dvs_dly) ? dvd_dly : dvs_dly;
        for (int c = 0; c <= last + lat; c++) begin
            seen |= bus.dividend_tvalid | bus.divisor_tvalid;
            if (bus.dividend_tvalid != 2'b00) dh++;
            if (bus.divisor_tvalid != 2'b00) vh++;
            bus.dividend_tready = (c == dvd_dly) ? mask : 2'b00;
            bus.divisor_tready  = (c == dvs_dly) ? mask : 2'b00;
            tick();
        end
        bus.dividend_tready = '0; bus.divisor_tready = '0;
        bus.dout_tvalid = mask;
        bus.dout_sdata  = s ? dout : ~dout;
        bus.dout_udata  = s ? ~dout : dout;
        tick();
        bus.dout_tvalid = '0;
        rv  = bus.resp_valid;
        res = bus.resp_result;
    endtask

    task automatic consume();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 resetn = 1'b0;
        #3;
        vectors++; if (bus.req_ready !== 1'b1) begin $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); miscompares++; end
        vectors++; if ({bus.dividend_tvalid, bus.divisor_tvalid} !== 4'b0000) begin $display("FAIL rst_tvalid: got %b want 0000", {bus.dividend_tvalid, bus.divisor_tvalid}); miscompares++; end
        vectors++; if ({bus.div_dividend_tdata, bus.div_divisor_tdata} !== 64'h0) begin $display("FAIL rst_tdata: got %h want 0", {bus.div_dividend_tdata, bus.div_divisor_tdata}); miscompares++; end
        vectors++; if ({bus.resp_valid, bus.resp_result} !== 33'h0) begin $display("FAIL rst_resp: got %b/%h want 0/0", bus.resp_valid, bus.resp_result); miscompares++; end
        vectors++; if (bus.err_timeout !== 1'b0) begin $display("FAIL rst_err: got %b want 0", bus.err_timeout); miscompares++; end
        tick(); tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_signed();
        // -7 / 2 = -3 rem -1
        run_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'h2, 0, 0, 5, {32'hFFFFFFFD, 32'hFFFFFFFF});
        vectors++; if (seen !== 2'b10) begin $display("FAIL s_ip_select: got %b want 10", seen); miscompares++; end
        vectors++; if (dd !== 32'hFFFFFFF9 || vd !== 32'h2) begin $display("FAIL s_tdata: got %h/%h want fffffff9/2", dd, vd); miscompares++; end
        vectors++; if (dh !== 1 || vh !== 1) begin $display("FAIL s_hold: got %0d/%0d want 1/1", dh, vh); miscompares++; end
        vectors++; if (rv !== 1'b1 || res !== 32'hFFFFFFFD) begin $display("FAIL s_quot: got %b/%h want 1/fffffffd", rv, res); miscompares++; end
        vectors++; if (bus.req_ready !== 1'b0) begin $display("FAIL s_busy: got %b want 0", bus.req_ready); miscompares++; end
        consume();
        vectors++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin $display("FAIL s_release: got %b/%b want 0/1", bus.resp_valid, bus.req_ready); miscompares++; end
        run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'h2, 0, 0, 5, {32'hFFFFFFFD, 32'hFFFFFFFF});
        vectors++; if (seen !== 2'b10 || rv !== 1'b1 || res !== 32'hFFFFFFFF) begin $display("FAIL s_rem: got %b/%b/%h want 10/1/ffffffff", seen, rv, res); miscompares++; end
        consume();
    endtask

    task automatic test_unsigned();
        // 0xFFFFFFFF / 16 = 0x0FFFFFFF rem 0xF; divisor tready 3 cycles late
        run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'h10, 0, 3, 4, {32'h0FFFFFFF, 32'h0000000F});
        vectors++; if (seen !== 2'b01) begin $display("FAIL u_ip_select: got %b want 01", seen); miscompares++; end
        vectors++; if (dh !== 1 || vh !== 4) begin $display("FAIL u_hold: got %0d/%0d want 1/4", dh, vh); miscompares++; end
        vectors++; if (rv !== 1'b1 || res !== 32'h0FFFFFFF) begin $display("FAIL u_quot: got %b/%h want 1/0fffffff", rv, res); miscompares++; end
        consume();
        run_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'h10, 0, 3, 4, {32'h0FFFFFFF, 32'h0000000F});
        vectors++; if (rv !== 1'b1 || res !== 32'h0000000F) begin $display("FAIL u_rem: got %b/%h want 1/0000000f", rv, res); miscompares++; end
        consume();
        // divide by zero: whatever the IP says goes through
        run_op(1'b0, 1'b0, 32'h5, 32'h0, 1, 0, 3, {32'hFFFFFFFF, 32'h00000005});
        vectors++; if (vd !== 32'h0 || res !== 32'hFFFFFFFF) begin $display("FAIL u_divzero: got %h/%h want 0/ffffffff", vd, res); miscompares++; end
        consume();
    endtask

    task automatic test_resp_hold();
        // 100 / 7 = 14 rem 2, EXE stalls for 5 cycles
        run_op(1'b0, 1'b0, 32'd100, 32'd7, 1, 1, 3, {32'd14, 32'd2});
        vectors++; if (rv !== 1'b1 || res !== 32'd14) begin $display("FAIL hold_first: got %b/%h want 1/e", rv, res); miscompares++; end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({bus.resp_valid, bus.req_ready, bus.resp_result} !== {1'b1, 1'b0, 32'd14}) begin
                $display("FAIL hold_cycle%0d: got valid=%b ready=%b res=%h want 1/0/e", i, bus.resp_valid, bus.req_ready, bus.resp_result); miscompares++;
            end
        end
        consume();
        vectors++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin $display("FAIL hold_release: got %b/%b want 1/0", bus.req_ready, bus.resp_valid); miscompares++; end
        vectors++; if (bus.err_timeout !== 1'b0) begin $display("FAIL hold_no_timeout: got %b want 0", bus.err_timeout); miscompares++; end
    endtask

    task automatic test_cancel_done_idle();
        run_op(1'b0, 1'b0, 32'd9, 32'd3, 0, 0, 2, {32'd3, 32'd0});
        bus.cancel = 1'b1; bus.resp_ready = 1'b1;
        #1;
        vectors++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin $display("FAIL cdone_mask: got %b/%b want 0/0", bus.resp_valid, bus.req_ready); miscompares++; end
        tick();
        bus.cancel = 1'b0; bus.resp_ready = 1'b0;
        #1;
        vectors++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin $display("FAIL cdone_idle: got %b/%b want 0/1", bus.resp_valid, bus.req_ready); miscompares++; end
        // request offered together with a cancel is refused
        bus.req_valid = 1'b1; bus.cancel = 1'b1;
        #1;
        vectors++; if (bus.req_ready !== 1'b0) begin $display("FAIL cidle_ready: got %b want 0", bus.req_ready); miscompares++; end
        tick();
        bus.req_valid = 1'b0; bus.cancel = 1'b0;
        #1;
        vectors++; if ({bus.dividend_tvalid, bus.divisor_tvalid, bus.req_ready} !== 5'b00001) begin $display("FAIL cidle_noissue: got %b want 00001", {bus.dividend_tvalid, bus.divisor_tvalid, bus.req_ready}); miscompares++; end
    endtask

    task automatic test_cancel_issue();
        // nothing accepted: abandon straight back to IDLE
        issue(1'b0, 1'b0, 32'd50, 32'd5);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        #1;
        vectors++; if ({bus.dividend_tvalid, bus.divisor_tvalid, bus.req_ready} !== 5'b00001) begin $display("FAIL cissue_none: got %b want 00001", {bus.dividend_tvalid, bus.divisor_tvalid, bus.req_ready}); miscompares++; end
        // dividend accepted, then cancel: divisor must still complete, then drain
        issue(1'b0, 1'b0, 32'd50, 32'd5);
        bus.dividend_tready = 2'b01;
        tick();
        bus.dividend_tready = 2'b00; bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        #1;
        vectors++; if ({bus.dividend_tvalid, bus.divisor_tvalid, bus.req_ready} !== 5'b00010) begin $display("FAIL cissue_part: got %b want 00010", {bus.dividend_tvalid, bus.divisor_tvalid, bus.req_ready}); miscompares++; end
        tick(); tick();
        vectors++; if (bus.divisor_tvalid !== 2'b01) begin $display("FAIL cissue_held: got %b want 01", bus.divisor_tvalid); miscompares++; end
        bus.divisor_tready = 2'b01;
        tick();
        bus.divisor_tready = 2'b00;
        vectors++; if ({bus.divisor_tvalid, bus.req_ready} !== 3'b000) begin $display("FAIL cissue_drain: got %b want 000", {bus.divisor_tvalid, bus.req_ready}); miscompares++; end
        tick(); tick();
        bus.dout_tvalid = 2'b01; bus.dout_udata = {32'd10, 32'd0};
        tick();
        bus.dout_tvalid = 2'b00;
        vectors++; if ({bus.req_ready, bus.resp_valid, bus.resp_result} !== {1'b1, 1'b0, 32'd3}) begin $display("FAIL cissue_end: got %b/%b/%h want 1/0/3", bus.req_ready, bus.resp_valid, bus.resp_result); miscompares++; end
    endtask

    task automatic test_cancel_wait();
        issue(1'b1, 1'b0, 32'd20, 32'd3);
        bus.dividend_tready = 2'b10; bus.divisor_tready = 2'b10;
        tick();
        bus.dividend_tready = 2'b00; bus.divisor_tready = 2'b00;
        tick(); tick(); tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        #1;
        vectors++; if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin $display("FAIL cwait_drain: got %b/%b want 0/0", bus.req_ready, bus.resp_valid); miscompares++; end
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        #1;
        vectors++; if (bus.req_ready !== 1'b0) begin $display("FAIL cwait_recancel: got %b want 0", bus.req_ready); miscompares++; end
        tick(); tick(); tick(); tick();
        vectors++; if (bus.req_ready !== 1'b0) begin $display("FAIL cwait_still: got %b want 0", bus.req_ready); miscompares++; end
        bus.dout_tvalid = 2'b10; bus.dout_sdata = {32'd6, 32'd2};
        tick();
        bus.dout_tvalid = 2'b00;
        vectors++; if ({bus.req_ready, bus.resp_valid, bus.resp_result} !== {1'b1, 1'b0, 32'd3}) begin $display("FAIL cwait_end: got %b/%b/%h want 1/0/3", bus.req_ready, bus.resp_valid, bus.resp_result); miscompares++; end
        vectors++; if (bus.err_timeout !== 1'b0) begin $display("FAIL cwait_no_timeout: got %b want 0", bus.err_timeout); miscompares++; end
    endtask

    task automatic test_timeout();
        issue(1'b0, 1'b0, 32'd1, 32'd1);
        bus.dividend_tready = 2'b01; bus.divisor_tready = 2'b01;
        tick();
        bus.dividend_tready = 2'b00; bus.divisor_tready = 2'b00;
        for (int i = 0; i < 7; i++) tick();
        vectors++; if (bus.err_timeout !== 1'b0) begin $display("FAIL tmo_early: got %b want 0", bus.err_timeout); miscompares++; end
        tick();
        vectors++; if (bus.err_timeout !== 1'b1) begin $display("FAIL tmo_set: got %b want 1", bus.err_timeout); miscompares++; end
        tick(); tick(); tick(); tick();
        vectors++; if (bus.err_timeout !== 1'b1 || bus.req_ready !== 1'b0) begin $display("FAIL tmo_sticky: got %b/%b want 1/0", bus.err_timeout, bus.req_ready); miscompares++; end
        #2 resetn = 1'b0;
        #1;
        vectors++; if ({bus.err_timeout, bus.dividend_tvalid, bus.divisor_tvalid, bus.req_ready} !== 6'b000001) begin $display("FAIL tmo_reset: got %b want 000001", {bus.err_timeout, bus.dividend_tvalid, bus.divisor_tvalid, bus.req_ready}); miscompares++; end
        #2 resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset_issue();
        issue(1'b1, 1'b0, 32'hFFFFFF9C, 32'd7);
        vectors++; if (bus.dividend_tvalid !== 2'b10 || bus.divisor_tvalid !== 2'b10) begin $display("FAIL rissue_pre: got %b/%b want 10/10", bus.dividend_tvalid, bus.divisor_tvalid); miscompares++; end
        #2 resetn = 1'b0;
        #1;
        vectors++; if ({bus.dividend_tvalid, bus.divisor_tvalid, bus.div_dividend_tdata, bus.resp_result} !== 68'h0) begin
            $display("FAIL rissue_async: got tvalid=%b/%b tdata=%h res=%h want all 0", bus.dividend_tvalid, bus.divisor_tvalid, bus.div_dividend_tdata, bus.resp_result); miscompares++;
        end
        #2 resetn = 1'b1;
        tick();
        // -100 / 7 = -14 rem -2
        run_op(1'b1, 1'b0, 32'hFFFFFF9C, 32'd7, 1, 0, 3, {32'hFFFFFFF2, 32'hFFFFFFFE});
        vectors++; if (rv !== 1'b1 || res !== 32'hFFFFFFF2) begin $display("FAIL rissue_after: got %b/%h want 1/fffffff2", rv, res); miscompares++; end
        consume();
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_resp_hold();
        test_cancel_done_idle();
        test_cancel_issue();
        test_cancel_wait();
        test_timeout();
        test_reset_issue();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
